// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter/multiplexer:
// FSM state encoding, parameter limits and a clog2 helper that never
// returns a zero-width index.
package bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } bus_state_e;

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 64;
  localparam int NUM_SRC_MIN  = 2;
  localparam int NUM_SRC_MAX  = 64;
  localparam int MAX_HOLD_MIN = 2;

  // Ceiling log2, clamped to at least 1 so index vectors are never empty.
  function automatic int safe_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < value) begin
        w = w + 1;
      end
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker. The eligible vector is rotated so the
// source just after the pointer sits at bit 0, the lowest set bit wins, and
// the winning offset is rotated back into an absolute source index.
module rr_priority_picker
  import bus_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int IDX_W   = safe_clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_SRC);

  logic [IDX_W-1:0]   start_idx;
  logic [NUM_SRC-1:0] rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum_ext;
  logic [IDX_W:0]     wrapped_ext;

  // Rotate so that the first candidate after the pointer lands at bit 0.
  always_comb begin
    start_idx = (ptr_i == LAST_IDX) ? '0 : ptr_i + IDX_W'(1);
    rotated   = NUM_SRC'({elig_i, elig_i} >> start_idx);
  end

  // Lowest set bit of the rotated vector; descending scan lets it win last.
  always_comb begin
    offset = '0;
    any_o  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = IDX_W'(i);
        any_o  = 1'b1;
      end
    end
  end

  // Map the rotated offset back to an absolute index, modulo NUM_SRC.
  always_comb begin
    sum_ext     = {1'b0, start_idx} + {1'b0, offset};
    wrapped_ext = (sum_ext >= NUM_EXT) ? sum_ext - NUM_EXT : sum_ext;
    win_idx_o   = IDX_W'(wrapped_ext);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
      assign win_onehot_o[gi] = any_o && (win_idx_o == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_rr_arbiter_mux.sv
// Round-robin arbitrated bus multiplexer. N sources request a shared bus;
// one owner is granted, held while its request stays high, and its word is
// registered onto bus_out together with grant/owner/valid status.
// Optional feature macro: BUS_TIMEOUT_EN (hold-timeout revoke of hogging
// owners with a per-source mask until the revoked request drops).
module bus_rr_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 32,
  parameter int IDX_W    = safe_clog2(NUM_SRC),
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       bus_grant,
  output logic [IDX_W-1:0]         bus_owner,
  output logic                     bus_valid,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_revoke
);

  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_SRC - 1);

  // Elaboration-time parameter range guards.
  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("bus_rr_arbiter_mux: WIDTH out of range");
    end
    if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
      $error("bus_rr_arbiter_mux: NUM_SRC out of range");
    end
    if (MAX_HOLD < MAX_HOLD_MIN) begin : g_bad_max_hold
      $error("bus_rr_arbiter_mux: MAX_HOLD must be at least 2");
    end
  endgenerate

  bus_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] owner_excl;
  logic [NUM_SRC-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               arbitrate;

  logic [WIDTH-1:0]   src_word [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_word[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef BUS_TIMEOUT_EN
  // hold_q counts completed hold edges since the grant; the owner has been
  // on the bus for MAX_HOLD cycles when it reaches MAX_HOLD-1.
  localparam int HOLD_W = safe_clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               revoke_q, revoke_d;
`endif

  // The current owner is never its own successor: on release its request is
  // already low, and on a revoke it must be skipped explicitly.
  always_comb begin
    owner_excl = (state_q == ST_OWNED) ? grant_q : '0;
`ifdef BUS_TIMEOUT_EN
    eligible   = src_req & ~owner_excl & ~mask_q;
`else
    eligible   = src_req & ~owner_excl;
`endif
  end

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .elig_i       (eligible),
    .ptr_i        (ptr_q),
    .win_onehot_o (pick_onehot),
    .win_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  // Next-state logic: decide hold vs. arbitrate, then apply the pick.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    out_d     = out_q;
    ptr_d     = ptr_q;
    arbitrate = 1'b0;
`ifdef BUS_TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask_q & src_req;
    revoke_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        arbitrate = 1'b1;
      end
      ST_OWNED: begin
        if (!src_req[owner_q]) begin
          arbitrate = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          arbitrate = 1'b1;
          revoke_d  = 1'b1;
          mask_d    = mask_d | grant_q;
        end
`endif
        else begin
          out_d = src_word[owner_q];
`ifdef BUS_TIMEOUT_EN
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arbitrate) begin
      if (pick_any) begin
        state_d = ST_OWNED;
        grant_d = pick_onehot;
        owner_d = pick_idx;
        valid_d = 1'b1;
        out_d   = src_word[pick_idx];
        ptr_d   = pick_idx;
`ifdef BUS_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers; clr takes priority over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      ptr_q    <= PTR_RESET;
`ifdef BUS_TIMEOUT_EN
      hold_q   <= '0;
      mask_q   <= '0;
      revoke_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      ptr_q    <= ptr_d;
`ifdef BUS_TIMEOUT_EN
      hold_q   <= hold_d;
      mask_q   <= mask_d;
      revoke_q <= revoke_d;
`endif
    end
  end

  assign bus_grant = grant_q;
  assign bus_owner = owner_q;
  assign bus_valid = valid_q;
  assign bus_out   = out_q;
`ifdef BUS_TIMEOUT_EN
  assign bus_revoke = revoke_q;
`else
  assign bus_revoke = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter_mux.sv
// Self-checking bench for bus_rr_arbiter_mux: directed scenarios followed by
// randomized request/data traffic, all compared every cycle against a
// behavioural round-robin model (owner number, pointer, hold count, mask).
module tb_bus_rr_arbiter_mux;

  localparam int WIDTH    = 32;
  localparam int NUM_SRC  = 32;
  localparam int IDX_W    = $clog2(NUM_SRC);
  localparam int MAX_HOLD = 4;

  logic                     clk = 1'b0;
  logic                     clr;
  logic [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       bus_grant;
  logic [IDX_W-1:0]         bus_owner;
  logic                     bus_valid;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_revoke;

  always #5 clk = ~clk;

  bus_rr_arbiter_mux #(
    .WIDTH    (WIDTH),
    .NUM_SRC  (NUM_SRC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .src_req    (src_req),
    .src_data   (src_data),
    .bus_grant  (bus_grant),
    .bus_owner  (bus_owner),
    .bus_valid  (bus_valid),
    .bus_out    (bus_out),
    .bus_revoke (bus_revoke)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state: owner number (-1 = bus free), last reported
  // owner, rr pointer, cycles owned so far, last bus word, revoke mask.
  int             m_owner;
  int             m_last_owner;
  int             m_ptr;
  int             m_held;
  logic [WIDTH-1:0] m_out;
  bit             m_revoke;
  bit             m_mask [NUM_SRC];

  int seq [$];
  int gaps;
  int prev_owner;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] word_of(input int src);
    return src_data[src*WIDTH +: WIDTH];
  endfunction

  // One clock edge of the arbiter as described in prose: reset, hold,
  // release, revoke, and a round-robin search starting after the pointer.
  task automatic model_step();
    bit arb;
    int win;
    bit nmask [NUM_SRC];
    m_revoke = 1'b0;
    if (clr) begin
      m_owner = -1; m_last_owner = 0; m_ptr = NUM_SRC - 1; m_held = 0; m_out = '0;
      for (int i = 0; i < NUM_SRC; i++) m_mask[i] = 1'b0;
      return;
    end
    for (int i = 0; i < NUM_SRC; i++) nmask[i] = m_mask[i] && src_req[i];
    arb = 1'b0;
    if (m_owner < 0) arb = 1'b1;
    else if (!src_req[m_owner]) arb = 1'b1;
`ifdef BUS_TIMEOUT_EN
    else if (m_held >= MAX_HOLD) begin
      arb = 1'b1; m_revoke = 1'b1; nmask[m_owner] = 1'b1;
    end
`endif
    else begin
      m_out = word_of(m_owner); m_held++;
    end
    if (arb) begin
      win = -1;
      for (int k = 1; k <= NUM_SRC; k++) begin
        int c;
        c = (m_ptr + k) % NUM_SRC;
        if (win < 0 && src_req[c] && !m_mask[c] && c != m_owner) win = c;
      end
      if (win >= 0) begin
        m_owner = win; m_last_owner = win; m_ptr = win; m_held = 1; m_out = word_of(win);
      end else begin
        m_owner = -1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) m_mask[i] = nmask[i];
  endtask

  task automatic check_outputs();
    logic [NUM_SRC-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    check_eq("grant",  64'(bus_grant),  64'(g));
    check_eq("owner",  64'(bus_owner),  64'(m_last_owner));
    check_eq("valid",  64'(bus_valid),  64'(m_owner >= 0));
    check_eq("out",    64'(bus_out),    64'(m_out));
    check_eq("revoke", 64'(bus_revoke), 64'(m_revoke));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    src_req = '0;
    src_data = '0;
    m_owner = -1; m_last_owner = 0; m_ptr = NUM_SRC - 1; m_held = 0; m_out = '0; m_revoke = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) m_mask[i] = 1'b0;

    // Scenario 1: reset with no requests, then a single request from source 3.
    for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
    tick();
    tick();
    check_eq("t1_rst_grant", 64'(bus_grant), 64'h0);
    check_eq("t1_rst_valid", 64'(bus_valid), 64'h0);
    check_eq("t1_rst_out",   64'(bus_out),   64'h0);
    clr = 1'b0;
    src_req[3] = 1'b1;
    src_data[3*WIDTH +: WIDTH] = 32'hA5A5_A5A5;
    tick();
    check_eq("t1_grant", 64'(bus_grant), 64'h8);
    check_eq("t1_owner", 64'(bus_owner), 64'd3);
    check_eq("t1_out",   64'(bus_out),   64'hA5A5_A5A5);
    src_req = '0;
    tick();
    check_eq("t1_release_valid", 64'(bus_valid), 64'h0);
    check_eq("t1_release_out",   64'(bus_out),   64'hA5A5_A5A5);
    $display("scenario 1 single request: grant=0x%0h owner=%0d", bus_grant, bus_owner);

    // Scenario 2: sources 0, 5, 9 each hold two cycles then release.
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
    src_req = '0;
    src_req[0] = 1'b1; src_req[5] = 1'b1; src_req[9] = 1'b1;
    seq.delete();
    gaps = 0;
    prev_owner = -1;
    for (int c = 0; c < 16 && src_req != '0; c++) begin
      tick();
      if (bus_valid) begin
        if (int'(bus_owner) != prev_owner) begin
          seq.push_back(int'(bus_owner));
          prev_owner = int'(bus_owner);
        end
      end else begin
        gaps++;
      end
      if (m_owner >= 0 && m_held >= 2) src_req[m_owner] = 1'b0;
    end
    check_eq("t2_count", 64'(seq.size()), 64'd3);
    while (seq.size() < 3) seq.push_back(-1);
    check_eq("t2_first",  64'(seq[0]), 64'd0);
    check_eq("t2_second", 64'(seq[1]), 64'd5);
    check_eq("t2_third",  64'(seq[2]), 64'd9);
    check_eq("t2_gaps",   64'(gaps),   64'd0);
    $display("scenario 2 handover chain: %0d owners, %0d idle gaps", seq.size(), gaps);

    // Scenario 3: owner 5 releases while 2 and 7 wait -> 7 then 2.
    do_reset();
    src_req = '0;
    src_req[5] = 1'b1;
    tick();
    src_req[2] = 1'b1; src_req[7] = 1'b1;
    tick();
    src_req[5] = 1'b0;
    tick();
    check_eq("t3_after5", 64'(bus_owner), 64'd7);
    src_req[7] = 1'b0;
    tick();
    check_eq("t3_after7", 64'(bus_owner), 64'd2);
    check_eq("t3_valid",  64'(bus_valid), 64'd1);
    src_req = '0;
    tick();
    $display("scenario 3 wrap order: last owner=%0d", bus_owner);

    // Scenario 4: highest source releases, wrap to 0; data lag of one cycle.
    do_reset();
    src_req = '0;
    src_req[NUM_SRC-1] = 1'b1;
    tick();
    src_req[0] = 1'b1;
    src_data[0 +: WIDTH] = 32'h11;
    tick();
    src_req[NUM_SRC-1] = 1'b0;
    tick();
    check_eq("t4_wrap_owner", 64'(bus_owner), 64'd0);
    check_eq("t4_first_word", 64'(bus_out),   64'h11);
    src_data[0 +: WIDTH] = 32'h22;
    tick();
    check_eq("t4_next_word",  64'(bus_out),   64'h22);
    src_req = '0;
    tick();
    $display("scenario 4 wrap and data lag: out=0x%0h", bus_out);

    // Scenario 5: reset while source 6 owns; afterwards 0 wins over 6.
    do_reset();
    src_req = '0;
    src_req[6] = 1'b1;
    tick();
    tick();
    check_eq("t5_owner6", 64'(bus_owner), 64'd6);
    src_req[0] = 1'b1;
    clr = 1'b1;
    tick();
    check_eq("t5_rst_grant", 64'(bus_grant), 64'h0);
    check_eq("t5_rst_valid", 64'(bus_valid), 64'h0);
    clr = 1'b0;
    tick();
    check_eq("t5_regrant", 64'(bus_grant), 64'h1);
    src_req = '0;
    tick();
    $display("scenario 5 reset mid-ownership: grant after reset went to source 0");

    // Scenario 6: source 1 stuck high, source 2 waiting.
    do_reset();
    src_req = '0;
    src_req[1] = 1'b1; src_req[2] = 1'b1;
    tick();
    check_eq("t6_owner1", 64'(bus_owner), 64'd1);
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      tick();
      check_eq("t6_hold_owner",  64'(bus_owner),  64'd1);
      check_eq("t6_hold_revoke", 64'(bus_revoke), 64'd0);
    end
    tick();
`ifdef BUS_TIMEOUT_EN
    check_eq("t6_revoke_pulse", 64'(bus_revoke), 64'd1);
    check_eq("t6_new_owner",    64'(bus_owner),  64'd2);
    tick();
    check_eq("t6_pulse_end",    64'(bus_revoke), 64'd0);
    src_req[2] = 1'b0;
    tick();
    check_eq("t6_masked_idle",  64'(bus_valid),  64'd0);
    src_req[1] = 1'b0;
    tick();
    src_req[1] = 1'b1;
    tick();
    check_eq("t6_unmasked",     64'(bus_owner),  64'd1);
`else
    for (int c = 0; c < 12; c++) begin
      tick();
      check_eq("t6_forever_owner",  64'(bus_owner),  64'd1);
      check_eq("t6_forever_revoke", 64'(bus_revoke), 64'd0);
    end
`endif
    src_req = '0;
    tick();
    $display("scenario 6 hold timeout behaviour checked");

    // Randomized traffic: sparse set of requesters first, then all sources.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 11) == 0) src_req[i] = ~src_req[i];
        src_data[i*WIDTH +: WIDTH] = $urandom;
      end
      if (c < 2000) src_req = src_req & 32'h8000_0231;
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    clr = 1'b0;
    $display("random traffic: 4000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
